// File: rtl/dsp_pkg.sv
// Shared DSP-column definitions: P width, accumulator state encoding and the
// round/shift/saturate helper used by requantization paths.
package dsp_pkg;

    localparam int P_W           = 48;
    localparam int ACC_W_DEFAULT = P_W;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } acc_state_t;

    typedef struct packed {
        logic signed [P_W-1:0] val;
        logic                  sat;
    } rq_t;

    // Round half toward +inf, arithmetic shift right, clamp to a signed out_w range.
    // One extra bit of headroom keeps the rounding add from overflowing.
    function automatic rq_t round_shift_sat(input logic signed [P_W-1:0] sum,
                                            input int sh,
                                            input int out_w);
        logic signed [P_W:0] ext;
        logic signed [P_W:0] rnd;
        logic signed [P_W:0] r;
        logic signed [P_W:0] maxv;
        logic signed [P_W:0] minv;
        rq_t                 res;
        ext  = {sum[P_W-1], sum};
        rnd  = (sh != 0) ? ((P_W+1)'(1) <<< (sh - 1)) : '0;
        r    = (ext + rnd) >>> sh;
        maxv = ((P_W+1)'(1) <<< (out_w - 1)) - (P_W+1)'(1);
        minv = ~maxv;
        res.sat = 1'b1;
        if (r > maxv) begin
            res.val = maxv[P_W-1:0];
        end else if (r < minv) begin
            res.val = minv[P_W-1:0];
        end else begin
            res.val = r[P_W-1:0];
            res.sat = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with register-driven outputs and same-cycle push/pop.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          valid,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign push_ok = push && (count != CW'(DEPTH));
    assign pop_ok  = pop && (count != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop_ok) count <= count + 1'b1;
            else if (!push_ok && pop_ok) count <= count - 1'b1;
        end
    end

    assign dout  = mem[rd_ptr];
    assign valid = (count != '0);

endmodule

// File: rtl/psum_requant.sv
// Accumulates DSP P partial sums per group, then rounds, shifts and saturates
// each group total into a small output FIFO.
module psum_requant
    import dsp_pkg::*;
#(
    parameter int ACC_W   = ACC_W_DEFAULT,
    parameter int OUT_W   = 8,
    parameter int SHIFT_W = 6,
    parameter int DEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SHIFT_W-1:0]      cfg_shift,
    input  logic signed [ACC_W-1:0] p_in,
    input  logic                    p_valid,
    input  logic                    p_last,
    output logic                    in_ready,
    output logic [OUT_W-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    input  logic                    sat_clr,
    output logic                    sat_flag,
    output logic                    busy
);

    localparam int CW = $clog2(DEPTH + 1);

    // Handshake: a beat transfers on p_valid && in_ready, a result on
    // out_valid && out_ready; both ready/valid outputs come straight from registers.

    acc_state_t              state;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] s1_sum;
    logic [SHIFT_W-1:0]      s1_shift;
    logic                    s1_valid;
    logic [CW-1:0]           fifo_count;
    logic                    accept;
    int                      sh_eff;
    rq_t                     rq;

    assign accept = p_valid && in_ready;
    assign sum    = ((state == IDLE) ? '0 : acc) + p_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            acc      <= '0;
            s1_sum   <= '0;
            s1_shift <= '0;
            s1_valid <= 1'b0;
        end else begin
            if (accept && p_last) begin
                s1_sum   <= sum;
                s1_shift <= cfg_shift;
                s1_valid <= 1'b1;
                acc      <= '0;
                state    <= IDLE;
            end else begin
                s1_valid <= 1'b0;
                if (accept) begin
                    acc   <= sum;
                    state <= ACCUM;
                end
            end
        end
    end

    always_comb begin
        sh_eff = (int'(s1_shift) > ACC_W - 1) ? ACC_W - 1 : int'(s1_shift);
        rq     = round_shift_sat(s1_sum, sh_eff, OUT_W);
    end

    // A saturating write outranks a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sat_flag <= 1'b0;
        else if (s1_valid && rq.sat) sat_flag <= 1'b1;
        else if (sat_clr) sat_flag <= 1'b0;
    end

    sync_fifo #(
        .W     (OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (s1_valid),
        .din   (rq.val[OUT_W-1:0]),
        .pop   (out_ready),
        .dout  (out_data),
        .valid (out_valid),
        .count (fifo_count)
    );

    assign in_ready = (int'(fifo_count) + int'(s1_valid)) < DEPTH;
    assign busy     = (state == ACCUM) || s1_valid || (fifo_count != '0);

endmodule

// File: tb/tb_psum_requant.sv
// Bench for psum_requant: directed literal checks plus a randomized run
// checked against a queue-based behavioural model.
module tb_psum_requant;

  localparam int ACC_W   = 48;
  localparam int OUT_W   = 8;
  localparam int SHIFT_W = 6;
  localparam int DEPTH   = 4;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [SHIFT_W-1:0]      cfg_shift;
  logic signed [ACC_W-1:0] p_in;
  logic                    p_valid;
  logic                    p_last;
  logic                    in_ready;
  logic [OUT_W-1:0]        out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    sat_clr;
  logic                    sat_flag;
  logic                    busy;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [OUT_W-1:0] exp_q[$];
  longint           model_acc    = 0;
  bit               model_sticky = 0;
  logic [OUT_W-1:0] m_r8;
  bit               m_sat;

  longint rnd_in[4]  = '{23, 24, -24, -25};
  longint rnd_exp[4] = '{1, 2, -1, -2};

  // clock / reset
  always #5 clk = ~clk;

  psum_requant #(
    .ACC_W   (ACC_W),
    .OUT_W   (OUT_W),
    .SHIFT_W (SHIFT_W),
    .DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_shift (cfg_shift),
    .p_in      (p_in),
    .p_valid   (p_valid),
    .p_last    (p_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sat_clr   (sat_clr),
    .sat_flag  (sat_flag),
    .busy      (busy)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint wrap48(input longint x);
    logic signed [47:0] t;
    t = x[47:0];
    return longint'(t);
  endfunction

  // Reference requant: floor((s + half) / 2^sh), then clamp to signed 8 bits.
  function automatic void model_requant(input longint s, input int sh_in,
                                        output logic [OUT_W-1:0] r8, output bit sat);
    int     sh;
    longint r;
    sh = (sh_in > ACC_W - 1) ? ACC_W - 1 : sh_in;
    r  = s;
    if (sh > 0) r = r + (longint'(1) <<< (sh - 1));
    r   = r >>> sh;
    sat = 1'b0;
    if (r > 127) begin r = 127; sat = 1'b1; end
    if (r < -128) begin r = -128; sat = 1'b1; end
    r8 = r[OUT_W-1:0];
  endfunction

  // model update and per-cycle compare, just after inputs settle
  always @(negedge clk) begin
    #1;
    if (rst) begin
      exp_q.delete();
      model_acc = 0;
    end else begin
      check("in_ready", longint'(in_ready), longint'(exp_q.size() < DEPTH));
      if (sat_clr) model_sticky = 1'b0;
      if (p_valid && in_ready) begin
        model_acc = wrap48(model_acc + longint'(p_in));
        if (p_last) begin
          model_requant(model_acc, int'(cfg_shift), m_r8, m_sat);
          exp_q.push_back(m_r8);
          model_sticky = model_sticky | m_sat;
          model_acc = 0;
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("pop_unexpected", longint'(out_valid), 0);
        else check("out_data", longint'($signed(out_data)), longint'($signed(exp_q.pop_front())));
      end
    end
  end

  // driver tasks (called positioned at a negedge)
  task automatic send_beat(input longint v, input bit last, input int sh);
    int budget;
    p_valid   = 1'b1;
    p_in      = v[ACC_W-1:0];
    p_last    = last;
    cfg_shift = SHIFT_W'(sh);
    budget    = 0;
    while (!in_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    check("send_accepted", longint'(in_ready), 1);
    @(negedge clk);
  endtask

  task automatic idle();
    p_valid = 1'b0;
    p_last  = 1'b0;
  endtask

  task automatic group1(input longint v, input int sh);
    send_beat(v, 1'b1, sh);
    idle();
  endtask

  task automatic wait_head(input string name, input longint exp);
    int budget;
    budget = 0;
    while (!out_valid && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    check({name, "_valid"}, longint'(out_valid), 1);
    check(name, longint'($signed(out_data)), exp);
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out_valid"}, longint'(out_valid), 0);
    check({tag, "_out_data"}, longint'($signed(out_data)), 0);
    check({tag, "_sat_flag"}, longint'(sat_flag), 0);
    check({tag, "_busy"}, longint'(busy), 0);
    check({tag, "_in_ready"}, longint'(in_ready), 1);
  endtask

  initial begin
    logic [63:0] big;
    int          sv;
    int          budget;
    rst = 1'b1; p_valid = 1'b0; p_in = '0; p_last = 1'b0; cfg_shift = '0;
    out_ready = 1'b0; sat_clr = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;
    @(negedge clk);

    // group 100,200,-50,6 shift 4 -> 16, two cycles after the last beat
    send_beat(100, 1'b0, 4);
    send_beat(200, 1'b0, 4);
    send_beat(-50, 1'b0, 4);
    send_beat(6, 1'b1, 4);
    idle();
    check("lat_n_out_valid", longint'(out_valid), 0);
    check("lat_n_busy", longint'(busy), 1);
    @(negedge clk);
    check("lat_n1_out_valid", longint'(out_valid), 1);
    check("group_out_data", longint'($signed(out_data)), 16);
    check("group_sat_flag", longint'(sat_flag), 0);
    pop_one();

    // rounding, shift 4
    for (int i = 0; i < 4; i++) begin
      group1(rnd_in[i], 4);
      wait_head("round", rnd_exp[i]);
      pop_one();
    end

    // saturation, shift 0
    group1(1000, 0);
    wait_head("sat_pos", 127);
    check("sat_pos_flag", longint'(sat_flag), 1);
    pop_one();
    sat_clr = 1'b1;
    @(negedge clk);
    sat_clr = 1'b0;
    check("sat_clr", longint'(sat_flag), 0);
    send_beat(-1000, 1'b1, 0);
    idle();
    sat_clr = 1'b1;
    @(negedge clk);
    sat_clr = 1'b0;
    check("sat_set_wins", longint'(sat_flag), 1);
    wait_head("sat_neg", -128);
    pop_one();
    sat_clr = 1'b1;
    @(negedge clk);
    sat_clr = 1'b0;

    // wrap: 4 x 2^46 = 2^48 wraps to 0
    for (int i = 0; i < 4; i++) send_beat(longint'(1) <<< 46, (i == 3), 0);
    idle();
    wait_head("wrap", 0);
    check("wrap_sat_flag", longint'(sat_flag), 0);
    pop_one();

    // backpressure: six single-beat groups with the consumer stalled
    fork
      begin
        for (int k = 1; k <= 6; k++) send_beat(k, 1'b1, 0);
        idle();
      end
      begin
        repeat (8) @(negedge clk);
        check("bp_in_ready_low", longint'(in_ready), 0);
        check("bp_out_valid", longint'(out_valid), 1);
        out_ready = 1'b1;
        for (int k = 1; k <= 6; k++) begin
          check("bp_order_valid", longint'(out_valid), 1);
          check("bp_order", longint'($signed(out_data)), k);
          @(negedge clk);
        end
        out_ready = 1'b0;
      end
    join

    // reset mid-group
    send_beat(50, 1'b0, 0);
    send_beat(50, 1'b0, 0);
    idle();
    @(posedge clk);
    #2 rst = 1'b1;
    #10 rst = 1'b0;
    @(negedge clk);
    check_reset_state("midrst");
    group1(7, 0);
    wait_head("after_rst", 7);
    pop_one();

    // randomized run
    sat_clr = 1'b1;
    @(negedge clk);
    sat_clr = 1'b0;
    repeat (400) begin
      p_valid = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 3) == 0) begin
        big  = {$urandom, $urandom};
        p_in = big[ACC_W-1:0];
      end else begin
        sv   = int'($urandom_range(0, 4000)) - 2000;
        p_in = ACC_W'(longint'(sv));
      end
      p_last    = ($urandom_range(0, 9) < 3);
      cfg_shift = ($urandom_range(0, 9) < 8) ? SHIFT_W'($urandom_range(0, 12))
                                             : SHIFT_W'($urandom_range(0, 63));
      out_ready = ($urandom_range(0, 9) < 6);
      @(negedge clk);
    end
    send_beat(1, 1'b1, 0);
    idle();
    out_ready = 1'b1;
    budget = 0;
    while ((exp_q.size() != 0 || busy) && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    check("drain_busy", longint'(busy), 0);
    check("drain_left", longint'(exp_q.size()), 0);
    check("rand_sat_flag", longint'(sat_flag), longint'(model_sticky));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/psum_requant.md
# psum_requant

Downstream stage of a DSP48E2 column. Consumes the 48-bit signed P output of the last DSP in a dot-product chain and accumulates successive partial sums over a group of beats terminated by `p_last`. At group end it rounds and arithmetic-right-shifts the total, saturates it to an OUT_W-bit signed activation, and buffers the result in a small FIFO behind a valid/ready output. `in_ready` is the backpressure signal that upstream control folds into the DSP `enable`.

## Interface
- `ACC_W`, 48: accumulator and P width; must match the DSP P width.
- `OUT_W`, 8: output activation width, signed.
- `SHIFT_W`, 6: width of the requant shift control.
- `DEPTH`, 4: output FIFO entries; power of two, ≥2.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `cfg_shift`  in  SHIFT_W  right-shift amount; sampled with the last beat of each group.
- `p_in`  in  ACC_W  signed partial sum from DSP P.
- `p_valid`  in  1  `p_in` is valid this cycle.
- `p_last`  in  1  marks the final beat of a group; meaningful only with `p_valid`.
- `in_ready`  out  1  beat is accepted when `p_valid && in_ready`.
- `out_data`  out  OUT_W  signed requantized result at the FIFO head.
- `out_valid`  out  1  FIFO is non-empty.
- `out_ready`  in  1  consumer pops the head when `out_valid && out_ready`.
- `sat_clr`  in  1  synchronous clear of `sat_flag`.
- `sat_flag`  out  1  sticky: a saturation occurred since reset or the last `sat_clr`.
- `busy`  out  1  group in progress, result in flight, or FIFO non-empty.

## Operation
- Two-state FSM.
  - IDLE: no partial group held.
  - ACCUM: `acc` holds a partial group.
- Accepted beat: `sum = (IDLE ? 0 : acc) + p_in`, ACC_W bits, two's-complement wrap, no saturation (matches the DSP ALU).
- Non-last beat: `acc <= sum`, go to ACCUM.
- Last beat:
  - `s1_sum <= sum`, `s1_shift <= cfg_shift`, `s1_valid <= 1`.
  - `acc <= 0`, go to IDLE.
  - A single-beat group from IDLE yields `sum = p_in`.
- Stage 2, on `s1_valid`:
  - Effective shift `sh = min(s1_shift, ACC_W-1)`.
  - `r = (s1_sum + (sh ? 1<<(sh-1) : 0)) >>> sh`, evaluated at ACC_W+1 bits (round half toward +inf).
  - Clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; a clamp sets `sat_flag`.
  - Write the result into the FIFO; `s1_valid` clears unless a new last beat is accepted the same cycle.
- `in_ready = (fifo_count + s1_valid) < DEPTH`, for every beat. Conservative: ignores a same-cycle pop.
- FIFO push and pop in the same cycle: both happen, count unchanged. Ordering is strict FIFO.
- `sat_clr` and a same-cycle saturation: the set wins.
- `busy = (state == ACCUM) | s1_valid | (fifo_count != 0)`.
- `cfg_shift` changes affect only groups whose last beat has not yet been accepted.

## Timing
- Reset values: `acc=0`, state IDLE, `s1_valid=0`, FIFO empty, `out_valid=0`, `out_data=0`, `sat_flag=0`, `busy=0`, `in_ready=1`.
- Reset mid-group or with results in flight discards all of them; the next accepted beat starts a new group.
- Latency: last beat accepted at edge N → `s1_valid` after N → FIFO write at N+1 → `out_valid` high after N+1 when the FIFO was empty. Two cycles.
- Throughput: one beat per cycle. Back-to-back single-beat groups produce one result per cycle while `out_ready` is held high.
- `in_ready` and `out_valid` are driven from registers only; no combinational path from `out_ready` or `p_valid`.
- `out_data` is held stable while `out_valid && !out_ready`.

## Structure
- Shared package `dsp_pkg`:
  - `ACC_W` default and the DSP P width constant.
  - Function `round_shift_sat(sum, sh)` returning the clamped value and a saturation bit, reusable by other requant paths.
  - Enum `acc_state_t {IDLE, ACCUM}`.
- One sub-module: `sync_fifo`, parameterized by width and depth.
  - Registered outputs; `count` port; simultaneous push and pop allowed.

## Test plan
- Group of beats 100, 200, -50, 6 with `cfg_shift=4`: sum 256, `(256+8)>>4` → `out_data=16`, `out_valid` high two cycles after the last beat, `sat_flag=0`.
- Rounding, shift 4, one single-beat group each:
  - 23 → 1.
  - 24 → 2.
  - -24 → -1.
  - -25 → -2.
- Saturation, shift 0:
  - Beat 1000 → 127.
  - Beat -1000 → -128.
  - `sat_flag=1` in both cases.
  - `sat_clr` pulse → 0.
  - `sat_clr` coincident with a saturating write → stays 1.
- Wrap: four beats of 2^46, shift 0 → sum wraps to 0 → `out_data=0`, no saturation.
- Backpressure, DEPTH=4, `out_ready=0`, six single-beat groups 1..6:
  - `in_ready` drops once 4 results are held or in flight.
  - Beats 5 and 6 are stalled, not lost.
  - Then `out_ready=1` → outputs 1..6 in order, one per cycle.
- Reset mid-operation:
  - Two beats of 50, then a 1-cycle `rst` asynchronous to the clock edge.
  - After reset, all outputs are at reset values.
  - Single beat 7 with shift 0 → `out_data=7`, not 107.
